cond_flag_unit: RTL and testbench
=================================

COND_FLAG_UNIT -- requirements
Module: cond_flag_unit

Interface
REQ-001 The module SHALL have one clock and an asynchronous active-low reset; port list:
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 alu_c, alu_n, alu_v, alu_z  input  1 each  condition codes from the ALU for the instruction in EX.
REQ-005 s_en  input  1  EX instruction is valid and updates flags.
REQ-006 cond_req  input  1  ID holds a conditional instruction needing evaluation.
REQ-007 cond  input  4  condition field of the ID instruction.
REQ-008 flush  input  1  kill the pending ID evaluation.
REQ-009 flags  output  4  registered {N,Z,C,V}.
REQ-010 cin  output  1  registered C, fed back as the ALU carry-in.
REQ-011 cond_true  output  1  registered evaluation result.
REQ-012 cond_valid  output  1  one-cycle strobe qualifying cond_true.
REQ-013 stall  output  1  registered; holds ID while an evaluation waits for in-flight flags.

Function
REQ-014 Flag register: on every rising edge with s_en=1, {N,Z,C,V} SHALL load {alu_n,alu_z,alu_c,alu_v}. With s_en=0 it SHALL hold. This applies in every state and regardless of flush.
REQ-015 cin SHALL always equal the registered C bit.
REQ-016 Condition table, evaluated on the flag-register value: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F NV 0.
REQ-017 The FSM SHALL have two states, IDLE and WAIT.
REQ-018 IDLE, edge with cond_req=1, s_en=0, flush=0:
  - cond_true <= eval(cond, current flags);
  - cond_valid <= 1;
  - stay in IDLE (1-cycle latency).
REQ-019 IDLE, edge with cond_req=1, s_en=1, flush=0 (flag hazard):
  - latch cond into cond_q;
  - stall <= 1; cond_valid <= 0;
  - go to WAIT.
REQ-020 WAIT, edge with s_en=0, flush=0:
  - cond_true <= eval(cond_q, flags written by the previous edge);
  - cond_valid <= 1; stall <= 0;
  - go to IDLE (2-cycle latency total).
REQ-021 WAIT, edge with s_en=1, flush=0:
  - stay in WAIT; stall stays 1; cond_valid <= 0.
  - Evaluation SHALL use only the newest flags.
REQ-022 cond_req SHALL be ignored in WAIT; upstream holds ID while stall=1.
REQ-023 flush=1 at any edge:
  - cond_valid <= 0; stall <= 0;
  - go to IDLE; discard cond_q;
  - the flag update per REQ-014 still occurs.
REQ-024 cond_valid SHALL be a single-cycle pulse per accepted request; cond_true SHALL hold its last value when cond_valid=0.
REQ-025 No evaluation SHALL ever use flags older than the most recent s_en write.

Reset
REQ-026 While reset_n=0, asynchronously:
  - flags = 4'b0000; cin = 0;
  - cond_true = 0; cond_valid = 0; stall = 0;
  - state = IDLE; cond_q = 0.
REQ-027 Reset asserted in WAIT SHALL abandon the evaluation; no cond_valid pulse follows reset release.

Verification
REQ-028 Reset, then s_en=1 with alu {c,n,v,z}=0001 -> next edge flags=0100 (Z=1), cin=0; then cond_req with cond=0 (EQ) -> cond_valid=1, cond_true=1 one cycle later.
REQ-029 flags N=1, V=0; request conds B (LT), A (GE), D (LE), C (GT) back-to-back, s_en=0 -> cond_true = 1, 0, 1, 0 on four consecutive cycles; stall stays 0.
REQ-030 Hazard: flags Z=0; same edge cond_req cond=0 and s_en=1 with alu_z=1 -> stall=1 for one cycle, then cond_true=1 with cond_valid=1, stall=0.
REQ-031 Double hazard: in WAIT, s_en=1 again with alu_z=0 -> WAIT extends one cycle; the final EQ result is cond_true=0.
REQ-032 flush asserted in WAIT together with s_en=1, alu_c=1 -> no cond_valid pulse, stall=0, state IDLE, cin=1 next cycle.
REQ-033 reset_n pulled low mid-WAIT, asynchronously between clock edges -> all outputs 0 immediately; cond=E (AL) request after release -> cond_true=1; cond=F -> cond_true=0.

Source files
------------

// File: rtl/cond_flag_unit.sv
// Condition-flag unit: holds the {N,Z,C,V} flag register written by the EX
// stage and evaluates the ID-stage condition field against it. When ID asks
// for an evaluation in the same cycle that EX is writing new flags, the
// request is parked until the flags settle, and ID is stalled meanwhile.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// ST_IDLE | no parked request; a request without a flag write resolves in 1 cycle
// ST_WAIT | request parked in cond_q; resolves on the first edge without s_en
module cond_flag_unit (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       alu_c,
   input  logic       alu_n,
   input  logic       alu_v,
   input  logic       alu_z,
   input  logic       s_en,
   input  logic       cond_req,
   input  logic [3:0] cond,
   input  logic       flush,
   output logic [3:0] flags,
   output logic       cin,
   output logic       cond_true,
   output logic       cond_valid,
   output logic       stall
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] cond_q, cond_q_d;
   logic [3:0] flags_d;
   logic       cond_true_d;
   logic       cond_valid_d;
   logic       stall_d;

   // Condition table over a {N,Z,C,V} flag vector.
   function automatic logic eval_cond(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cf, v;
      n  = f[3];
      z  = f[2];
      cf = f[1];
      v  = f[0];
      case (c)
         4'h0:    eval_cond = z;
         4'h1:    eval_cond = !z;
         4'h2:    eval_cond = cf;
         4'h3:    eval_cond = !cf;
         4'h4:    eval_cond = n;
         4'h5:    eval_cond = !n;
         4'h6:    eval_cond = v;
         4'h7:    eval_cond = !v;
         4'h8:    eval_cond = cf & !z;
         4'h9:    eval_cond = !cf | z;
         4'hA:    eval_cond = (n == v);
         4'hB:    eval_cond = (n != v);
         4'hC:    eval_cond = !z & (n == v);
         4'hD:    eval_cond = z | (n != v);
         4'hE:    eval_cond = 1'b1;
         default: eval_cond = 1'b0;
      endcase
   endfunction

   // Carry-in is simply the registered C bit.
   assign cin = flags[1];

   // Next-state and next-output logic; the flag write is independent of the FSM.
   always_comb begin
      state_d      = state_q;
      cond_q_d     = cond_q;
      cond_true_d  = cond_true;
      cond_valid_d = 1'b0;
      stall_d      = 1'b0;
      flags_d      = s_en ? {alu_n, alu_z, alu_c, alu_v} : flags;

      if (flush) begin
         state_d  = ST_IDLE;
         cond_q_d = 4'h0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cond_req) begin
                  if (s_en) begin
                     // Flags are being overwritten this edge: park the request.
                     cond_q_d = cond;
                     stall_d  = 1'b1;
                     state_d  = ST_WAIT;
                  end else begin
                     cond_true_d  = eval_cond(cond, flags);
                     cond_valid_d = 1'b1;
                  end
               end
            end
            ST_WAIT: begin
               if (s_en) begin
                  // Another write in flight; keep waiting for the newest flags.
                  stall_d = 1'b1;
               end else begin
                  cond_true_d  = eval_cond(cond_q, flags);
                  cond_valid_d = 1'b1;
                  state_d      = ST_IDLE;
               end
            end
         endcase
      end
   end

   // State, flag and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         cond_q     <= 4'h0;
         flags      <= 4'b0000;
         cond_true  <= 1'b0;
         cond_valid <= 1'b0;
         stall      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cond_q     <= cond_q_d;
         flags      <= flags_d;
         cond_true  <= cond_true_d;
         cond_valid <= cond_valid_d;
         stall      <= stall_d;
      end
   end

endmodule

// File: tb/tb_cond_flag_unit.sv
// Bench for cond_flag_unit: directed scenarios plus a condition-table sweep.
// Expected cond_true values are pushed when a request is driven and popped
// by a monitor whenever the DUT raises cond_valid.
module tb_cond_flag_unit;

   logic       clk;
   logic       reset_n;
   logic       alu_c, alu_n, alu_v, alu_z;
   logic       s_en;
   logic       cond_req;
   logic [3:0] cond;
   logic       flush;
   logic [3:0] flags;
   logic       cin;
   logic       cond_true;
   logic       cond_valid;
   logic       stall;

   int   n_vec = 0;
   int   n_err = 0;
   logic sb_q[$];

   logic [3:0]  flg_tab [4];
   logic [15:0] exp_tab [4];

   cond_flag_unit dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .alu_c      (alu_c),
      .alu_n      (alu_n),
      .alu_v      (alu_v),
      .alu_z      (alu_z),
      .s_en       (s_en),
      .cond_req   (cond_req),
      .cond       (cond),
      .flush      (flush),
      .flags      (flags),
      .cin        (cin),
      .cond_true  (cond_true),
      .cond_valid (cond_valid),
      .stall      (stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // f is {N,Z,C,V}, matching the flags output ordering.
   task automatic set_in(input logic se, input logic [3:0] f, input logic rq,
                         input logic [3:0] cd, input logic fl);
      s_en     = se;
      alu_n    = f[3];
      alu_z    = f[2];
      alu_c    = f[1];
      alu_v    = f[0];
      cond_req = rq;
      cond     = cd;
      flush    = fl;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_flags(input logic [3:0] f);
      set_in(1'b1, f, 1'b0, 4'h0, 1'b0);
      tick();
      chk("flag_load", flags, f);
   endtask

   // Scoreboard consumer: every cond_valid pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (reset_n && cond_valid) begin
         if (sb_q.size() == 0)
            chk("unexpected_valid", 1, 0);
         else
            chk("cond_true", cond_true, sb_q.pop_front());
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      flg_tab[0] = 4'b1000; exp_tab[0] = 16'h6A9A;
      flg_tab[1] = 4'b0110; exp_tab[1] = 16'h66A5;
      flg_tab[2] = 4'b0001; exp_tab[2] = 16'h6A6A;
      flg_tab[3] = 4'b0010; exp_tab[3] = 16'h55A6;

      reset_n = 1'b1;
      set_in(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
      #1 reset_n = 1'b0;
      #1;
      chk("rst_flags", flags, 4'h0);
      chk("rst_outs", {cin, cond_true, cond_valid, stall}, 4'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;

      // Flag load then a 1-cycle EQ evaluation.
      load_flags(4'b0100);
      chk("cin_after_load", cin, 0);
      set_in(1'b0, 4'h0, 1'b1, 4'h0, 1'b0);
      sb_q.push_back(1'b1);
      tick();
      chk("eq_valid", cond_valid, 1);
      set_in(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
      tick();
      chk("valid_single_pulse", cond_valid, 0);
      chk("cond_true_hold", cond_true, 1);

      // Back-to-back signed compares with N=1, V=0.
      load_flags(4'b1000);
      begin
         logic [3:0] seq [4];
         logic       res [4];
         seq[0] = 4'hB; res[0] = 1'b1;
         seq[1] = 4'hA; res[1] = 1'b0;
         seq[2] = 4'hD; res[2] = 1'b1;
         seq[3] = 4'hC; res[3] = 1'b0;
         for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 4'h0, 1'b1, seq[i], 1'b0);
            sb_q.push_back(res[i]);
            tick();
            chk("b2b_valid", cond_valid, 1);
            chk("b2b_stall", stall, 0);
         end
      end

      // Full condition-table sweep on several flag patterns.
      for (int p = 0; p < 4; p++) begin
         load_flags(flg_tab[p]);
         for (int c = 0; c < 16; c++) begin
            set_in(1'b0, 4'h0, 1'b1, 4'(c), 1'b0);
            sb_q.push_back(exp_tab[p][c]);
            tick();
         end
         chk("sweep_cin", cin, 32'(flg_tab[p][1]));
      end

      // Hazard: request in the same cycle as a flag write setting Z.
      load_flags(4'b0000);
      set_in(1'b1, 4'b0100, 1'b1, 4'h0, 1'b0);
      sb_q.push_back(1'b1);
      tick();
      chk("hz_stall", stall, 1);
      chk("hz_valid_low", cond_valid, 0);
      // ID held, but a changed cond field must be ignored while parked.
      set_in(1'b0, 4'h0, 1'b1, 4'hF, 1'b0);
      tick();
      chk("hz_resolve_valid", cond_valid, 1);
      chk("hz_resolve_stall", stall, 0);
      set_in(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
      tick();

      // Double hazard: second write clears Z while parked.
      set_in(1'b1, 4'b0100, 1'b1, 4'h0, 1'b0);
      sb_q.push_back(1'b0);
      tick();
      chk("dh_stall1", stall, 1);
      set_in(1'b1, 4'b0000, 1'b0, 4'h0, 1'b0);
      tick();
      chk("dh_stall2", stall, 1);
      chk("dh_valid_low", cond_valid, 0);
      chk("dh_flags", flags, 4'b0000);
      set_in(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
      tick();
      chk("dh_valid", cond_valid, 1);
      chk("dh_stall0", stall, 0);
      tick();

      // Flush in WAIT with a concurrent flag write setting C.
      set_in(1'b1, 4'b0000, 1'b1, 4'h0, 1'b0);
      tick();
      chk("fl_stall_pre", stall, 1);
      set_in(1'b1, 4'b0010, 1'b0, 4'h0, 1'b1);
      tick();
      chk("fl_stall", stall, 0);
      chk("fl_valid", cond_valid, 0);
      chk("fl_cin", cin, 1);
      chk("fl_flags", flags, 4'b0010);
      set_in(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
      tick();
      chk("fl_no_pulse", cond_valid, 0);
      // Flush also kills a request arriving in IDLE.
      set_in(1'b0, 4'h0, 1'b1, 4'h2, 1'b1);
      tick();
      chk("fl_idle_kill", cond_valid, 0);
      // Back in IDLE: a plain request resolves in one cycle.
      set_in(1'b0, 4'h0, 1'b1, 4'h2, 1'b0);
      sb_q.push_back(1'b1);
      tick();
      chk("fl_idle_check", cond_valid, 1);

      // Asynchronous reset while parked in WAIT.
      set_in(1'b1, 4'b1010, 1'b1, 4'h0, 1'b0);
      tick();
      chk("rw_stall_pre", stall, 1);
      set_in(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
      #2 reset_n = 1'b0;
      #1;
      chk("rw_flags", flags, 4'h0);
      chk("rw_outs", {cin, cond_true, cond_valid, stall}, 4'h0);
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      chk("rw_no_pulse1", cond_valid, 0);
      tick();
      chk("rw_no_pulse2", cond_valid, 0);
      set_in(1'b0, 4'h0, 1'b1, 4'hE, 1'b0);
      sb_q.push_back(1'b1);
      tick();
      chk("rw_al_valid", cond_valid, 1);
      set_in(1'b0, 4'h0, 1'b1, 4'hF, 1'b0);
      sb_q.push_back(1'b0);
      tick();
      chk("rw_nv_valid", cond_valid, 1);
      set_in(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
      tick();
      tick();

      chk("sb_drain", sb_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
